line_raster: RTL and testbench

- Consumer end of the vector line queue.
- Pops one line record at a time (start/end X/Y, 4-bit intensity) from the queue the AVG core fills, and rasterizes it with Bresenham.
- Emits one pixel write per cycle to the framebuffer write port over a valid/ready handshake.
- Maps AVG coordinate space to screen space and clips, so off-screen vectors never reach memory.

---
 rtl/line_raster_pkg.sv | 23 ++
 rtl/line_raster_coord_map.sv | 39 +++
 rtl/line_raster.sv | 190 +++++++++++++++++++
 tb/tb_line_raster.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_raster_pkg.sv
// Shared types and widths for the vector line rasterizer.
// Optional feature macro: LINE_RASTER_BLANK_DROP_EN (see line_raster.sv).
package line_raster_pkg;

    localparam int COORD_W = 13;  // AVG coordinate width (signed)
    localparam int SCR_W   = 12;  // screen-space working width (signed)

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        DRAW
    } state_t;

    // One popped queue record, AVG coordinates as delivered by the queue.
    typedef struct packed {
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [COORD_W-1:0] ex;
        logic [COORD_W-1:0] ey;
        logic [3:0]         intensity;
    } line_t;

endpackage

// File: rtl/line_raster_coord_map.sv
// AVG-to-screen coordinate transform plus visible-window flag.
// With MAP_EN=0 the input is already a screen coordinate and only the
// window test is applied.
module coord_map
    import line_raster_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_OFF       = 320,
    parameter int Y_OFF       = 240,
    parameter int COORD_SHIFT = 3,
    parameter bit MAP_EN      = 1'b1
) (
    input  logic signed [COORD_W-1:0] x_i,
    input  logic signed [COORD_W-1:0] y_i,
    output logic signed [SCR_W-1:0]   sx_o,
    output logic signed [SCR_W-1:0]   sy_o,
    output logic                      in_win_o
);

    localparam logic signed [SCR_W-1:0] X_OFF_S = SCR_W'(X_OFF);
    localparam logic signed [SCR_W-1:0] Y_OFF_S = SCR_W'(Y_OFF);
    localparam logic signed [SCR_W-1:0] W_LIM   = SCR_W'(SCREEN_W);
    localparam logic signed [SCR_W-1:0] H_LIM   = SCR_W'(SCREEN_H);

    // Scale/offset into screen space (Y axis flips), then test the window.
    always_comb begin
        if (MAP_EN) begin
            sx_o = SCR_W'(x_i >>> COORD_SHIFT) + X_OFF_S;
            sy_o = Y_OFF_S - SCR_W'(y_i >>> COORD_SHIFT);
        end else begin
            sx_o = SCR_W'(x_i);
            sy_o = SCR_W'(y_i);
        end
        in_win_o = !sx_o[SCR_W-1] && (sx_o < W_LIM) &&
                   !sy_o[SCR_W-1] && (sy_o < H_LIM);
    end

endmodule

// File: rtl/line_raster.sv
// Vector line queue consumer: pops one line, maps it to screen space and
// rasterizes it with Bresenham, one pixel write per cycle over valid/ready.
// Off-screen points are stepped through with pix_valid low.
// Optional feature macro: LINE_RASTER_BLANK_DROP_EN -- when defined, lines
// with zero intensity are dropped in SETUP and produce no pixel cycles.
module line_raster
    import line_raster_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int X_OFF       = 320,
    parameter int Y_OFF       = 240,
    parameter int COORD_SHIFT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] q_start_x,
    input  logic [12:0] q_start_y,
    input  logic [12:0] q_end_x,
    input  logic [12:0] q_end_y,
    input  logic [3:0]  q_intensity,
    input  logic        q_empty,
    output logic        q_read,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [3:0]  pix_color,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy
);

    localparam logic signed [SCR_W-1:0] STEP_P = SCR_W'(1);
    localparam logic signed [SCR_W-1:0] STEP_N = SCR_W'(-1);
    localparam logic signed [SCR_W-1:0] STEP_Z = SCR_W'(0);

    state_t state_q, state_d;
    line_t  line_q, line_d;

    logic signed [SCR_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic signed [SCR_W-1:0]   ex_q, ex_d, ey_q, ey_d;
    logic signed [SCR_W-1:0]   stepx_q, stepx_d, stepy_q, stepy_d;
    logic signed [COORD_W-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic signed [COORD_W-1:0] ddx, ddy;
    logic signed [COORD_W:0]   e2;

    logic signed [SCR_W-1:0] st_sx, st_sy, en_sx, en_sy, cur_sx, cur_sy;
    logic                    st_in, en_in, cur_in;
    logic                    unused_bits;

    coord_map #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_OFF(X_OFF),
        .Y_OFF(Y_OFF), .COORD_SHIFT(COORD_SHIFT), .MAP_EN(1'b1)
    ) u_map_start (
        .x_i(line_q.sx), .y_i(line_q.sy),
        .sx_o(st_sx), .sy_o(st_sy), .in_win_o(st_in)
    );

    coord_map #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_OFF(X_OFF),
        .Y_OFF(Y_OFF), .COORD_SHIFT(COORD_SHIFT), .MAP_EN(1'b1)
    ) u_map_end (
        .x_i(line_q.ex), .y_i(line_q.ey),
        .sx_o(en_sx), .sy_o(en_sy), .in_win_o(en_in)
    );

    coord_map #(
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .X_OFF(X_OFF),
        .Y_OFF(Y_OFF), .COORD_SHIFT(COORD_SHIFT), .MAP_EN(1'b0)
    ) u_map_cur (
        .x_i({cx_q[SCR_W-1], cx_q}), .y_i({cy_q[SCR_W-1], cy_q}),
        .sx_o(cur_sx), .sy_o(cur_sy), .in_win_o(cur_in)
    );

    // Endpoint window flags and the sign/high bits of the current point are
    // not needed: clipping is decided per point, and in-window points fit
    // the narrow pixel ports.
    assign unused_bits = ^{st_in, en_in, cur_sx[SCR_W-1:10], cur_sy[SCR_W-1:9]};

    assign pix_x     = cur_sx[9:0];
    assign pix_y     = cur_sy[8:0];
    assign pix_color = line_q.intensity;
    assign busy      = (state_q != IDLE);

    // Next-state: pop in IDLE, Bresenham setup, then per-point draw/step.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        ex_d      = ex_q;
        ey_d      = ey_q;
        stepx_d   = stepx_q;
        stepy_d   = stepy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        ddx       = '0;
        ddy       = '0;
        e2        = '0;
        q_read    = 1'b0;
        pix_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Gated by rst so a pop is never lost to a reset cycle.
                if (!q_empty && !rst) begin
                    q_read           = 1'b1;
                    line_d.sx        = q_start_x;
                    line_d.sy        = q_start_y;
                    line_d.ex        = q_end_x;
                    line_d.ey        = q_end_y;
                    line_d.intensity = q_intensity;
                    state_d          = SETUP;
                end
            end

            SETUP: begin
                ddx     = {en_sx[SCR_W-1], en_sx} - {st_sx[SCR_W-1], st_sx};
                ddy     = {en_sy[SCR_W-1], en_sy} - {st_sy[SCR_W-1], st_sy};
                cx_d    = st_sx;
                cy_d    = st_sy;
                ex_d    = en_sx;
                ey_d    = en_sy;
                dx_d    = ddx[COORD_W-1] ? -ddx : ddx;
                dy_d    = ddy[COORD_W-1] ? ddy : -ddy;
                err_d   = dx_d + dy_d;
                stepx_d = ddx[COORD_W-1] ? STEP_N : ((ddx != '0) ? STEP_P : STEP_Z);
                stepy_d = ddy[COORD_W-1] ? STEP_N : ((ddy != '0) ? STEP_P : STEP_Z);
                state_d = DRAW;
`ifdef LINE_RASTER_BLANK_DROP_EN
                if (line_q.intensity == 4'd0) begin
                    state_d = IDLE;
                end
`endif
            end

            DRAW: begin
                pix_valid = cur_in;
                // Clipped points retire unconditionally; visible ones wait for ready.
                if (!cur_in || pix_ready) begin
                    if ((cx_q == ex_q) && (cy_q == ey_q)) begin
                        state_d = IDLE;
                    end else begin
                        e2 = {err_q, 1'b0};
                        if (e2 >= $signed({dy_q[COORD_W-1], dy_q})) begin
                            err_d = err_d + dy_q;
                            cx_d  = cx_q + stepx_q;
                        end
                        if (e2 <= $signed({dx_q[COORD_W-1], dx_q})) begin
                            err_d = err_d + dx_q;
                            cy_d  = cy_q + stepy_q;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            line_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            ex_q    <= '0;
            ey_q    <= '0;
            stepx_q <= '0;
            stepy_q <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            ex_q    <= ex_d;
            ey_q    <= ey_d;
            stepx_q <= stepx_d;
            stepy_q <= stepy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_line_raster.sv
// Directed self-checking bench for line_raster.
// Inputs are driven just after the falling edge; outputs are sampled 1ns
// later, so each sample shows what the next rising edge will consume.
module tb_line_raster;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] q_start_x, q_start_y, q_end_x, q_end_y;
    logic [3:0]  q_intensity;
    logic        q_empty;
    logic        q_read;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [3:0]  pix_color;
    logic        pix_valid;
    logic        pix_ready;
    logic        busy;

    always #5 clk = ~clk;

    line_raster dut (
        .clk(clk), .rst(rst),
        .q_start_x(q_start_x), .q_start_y(q_start_y),
        .q_end_x(q_end_x), .q_end_y(q_end_y),
        .q_intensity(q_intensity), .q_empty(q_empty), .q_read(q_read),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Capture of one line's activity
    int acc_x[$], acc_y[$], acc_c[$];
    int pop_c, first_v, last_acc, end_c, busy_cnt, qread_cnt, v321_cnt;

    task automatic drive_head(input int sx, input int sy, input int ex, input int ey, input int ci);
        q_start_x   = 13'(sx);
        q_start_y   = 13'(sy);
        q_end_x     = 13'(ex);
        q_end_y     = 13'(ey);
        q_intensity = 4'(ci);
    endtask

    // Queue one line, pop it, and record every accepted pixel until busy drops.
    task automatic run_line(input int sx, input int sy, input int ex, input int ey,
                            input int ci, input int stall_len);
        int  stalls = 0;
        bit  popped = 1'b0;
        bit  done   = 1'b0;
        acc_x.delete(); acc_y.delete(); acc_c.delete();
        pop_c = -1; first_v = -1; last_acc = -1; end_c = -1;
        busy_cnt = 0; qread_cnt = 0; v321_cnt = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (!popped) begin
                drive_head(sx, sy, ex, ey, ci);
                q_empty = 1'b0;
            end else begin
                q_empty = 1'b1;
            end
            pix_ready = !(acc_x.size() == 1 && stalls < stall_len);
            #1;
            if (q_read) begin
                qread_cnt++;
                if (!popped) pop_c = c;
                popped = 1'b1;
            end
            if (busy) busy_cnt++;
            if (pix_valid) begin
                if (first_v < 0) first_v = c;
                if (pix_x == 10'd321) v321_cnt++;
                if (pix_ready) begin
                    acc_x.push_back(int'(pix_x));
                    acc_y.push_back(int'(pix_y));
                    acc_c.push_back(int'(pix_color));
                    last_acc = c;
                end else begin
                    stalls++;
                end
            end
            if (popped && c > pop_c && !busy) begin
                done  = 1'b1;
                end_c = c;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL run_line_timeout: line (%0d,%0d)->(%0d,%0d) did not finish within 300 cycles, required finish",
                     sx, sy, ex, ey);
        end
        q_empty   = 1'b1;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; q_empty = 1'b1; pix_ready = 1'b1;
        drive_head(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({q_read, pix_valid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: q_read/pix_valid/busy got %b%b%b want 000", q_read, pix_valid, busy);
        end
        n_checks++;
        if ({pix_x, pix_y, pix_color} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_pix: pix_x=%0d pix_y=%0d color=%0d want 0 0 0", pix_x, pix_y, pix_color);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++;
            if (q_read !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_no_pop: q_read=%b busy=%b want 0 0", q_read, busy);
            end
        end
    endtask

    task automatic test_horizontal();
        run_line(0, 0, 80, 0, 5, 0);
        n_checks++;
        if (acc_x.size() !== 11) begin
            n_fail++;
            $display("FAIL horiz_count: got %0d pixels want 11", acc_x.size());
        end
        for (int i = 0; i < acc_x.size() && i < 11; i++) begin
            n_checks++;
            if (acc_x[i] !== 320 + i || acc_y[i] !== 240 || acc_c[i] !== 5) begin
                n_fail++;
                $display("FAIL horiz_pix[%0d]: got (%0d,%0d,c%0d) want (%0d,240,c5)",
                         i, acc_x[i], acc_y[i], acc_c[i], 320 + i);
            end
        end
        n_checks++;
        if (qread_cnt !== 1) begin
            n_fail++;
            $display("FAIL horiz_qread: got %0d pulses want 1", qread_cnt);
        end
        n_checks++;
        if (first_v - pop_c !== 2) begin
            n_fail++;
            $display("FAIL horiz_latency: got %0d cycles want 2", first_v - pop_c);
        end
        n_checks++;
        if (busy_cnt !== 12) begin
            n_fail++;
            $display("FAIL horiz_busy: got %0d busy cycles want 12", busy_cnt);
        end
    endtask

    task automatic test_diagonal();
        run_line(0, 0, 40, 40, 3, 0);
        n_checks++;
        if (acc_x.size() !== 6) begin
            n_fail++;
            $display("FAIL diag_count: got %0d pixels want 6", acc_x.size());
        end
        for (int i = 0; i < acc_x.size() && i < 6; i++) begin
            n_checks++;
            if (acc_x[i] !== 320 + i || acc_y[i] !== 240 - i) begin
                n_fail++;
                $display("FAIL diag_pix[%0d]: got (%0d,%0d) want (%0d,%0d)",
                         i, acc_x[i], acc_y[i], 320 + i, 240 - i);
            end
        end
        n_checks++;
        if (end_c !== last_acc + 1) begin
            n_fail++;
            $display("FAIL diag_busy_drop: busy fell at %0d want %0d", end_c, last_acc + 1);
        end
    endtask

    task automatic test_clip();
        run_line(2520, 0, 2600, 0, 9, 0);
        n_checks++;
        if (acc_x.size() !== 5) begin
            n_fail++;
            $display("FAIL clip_count: got %0d pixels want 5", acc_x.size());
        end
        for (int i = 0; i < acc_x.size() && i < 5; i++) begin
            n_checks++;
            if (acc_x[i] !== 635 + i || acc_y[i] !== 240) begin
                n_fail++;
                $display("FAIL clip_pix[%0d]: got (%0d,%0d) want (%0d,240)", i, acc_x[i], acc_y[i], 635 + i);
            end
        end
        n_checks++;
        if (busy_cnt - 1 - acc_x.size() !== 6) begin
            n_fail++;
            $display("FAIL clip_cycles: got %0d clipped cycles want 6", busy_cnt - 1 - acc_x.size());
        end
        n_checks++;
        if (busy_cnt + 1 !== 13) begin
            n_fail++;
            $display("FAIL clip_total: got %0d line cycles want 13", busy_cnt + 1);
        end
    endtask

    task automatic test_backpressure();
        run_line(0, 0, 80, 0, 6, 3);
        n_checks++;
        if (acc_x.size() !== 11) begin
            n_fail++;
            $display("FAIL bp_count: got %0d pixels want 11", acc_x.size());
        end
        for (int i = 0; i < acc_x.size() && i < 11; i++) begin
            n_checks++;
            if (acc_x[i] !== 320 + i || acc_y[i] !== 240) begin
                n_fail++;
                $display("FAIL bp_pix[%0d]: got (%0d,%0d) want (%0d,240)", i, acc_x[i], acc_y[i], 320 + i);
            end
        end
        n_checks++;
        if (v321_cnt !== 4) begin
            n_fail++;
            $display("FAIL bp_hold: x=321 valid for %0d cycles want 4", v321_cnt);
        end
        n_checks++;
        if (busy_cnt !== 15) begin
            n_fail++;
            $display("FAIL bp_busy: got %0d busy cycles want 15", busy_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int  pops[$];
        int  px[$], py[$], pc[$];
        int  exp_x[6] = '{320, 321, 322, 320, 320, 320};
        int  exp_y[6] = '{240, 240, 240, 240, 239, 238};
        int  exp_c[6] = '{3, 3, 3, 9, 9, 9};
        int  next_line = 0;
        int  consec = 0;
        bit  prev_qr = 1'b0;
        bit  done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (next_line == 0) begin
                drive_head(0, 0, 16, 0, 3); q_empty = 1'b0;
            end else if (next_line == 1) begin
                drive_head(0, 0, 0, 16, 9); q_empty = 1'b0;
            end else begin
                q_empty = 1'b1;
            end
            pix_ready = 1'b1;
            #1;
            if (q_read) begin
                pops.push_back(c);
                if (prev_qr) consec++;
                next_line++;
            end
            prev_qr = q_read;
            if (pix_valid) begin
                px.push_back(int'(pix_x)); py.push_back(int'(pix_y)); pc.push_back(int'(pix_color));
            end
            if (pops.size() == 2 && c > pops[1] && !busy) done = 1'b1;
        end
        q_empty = 1'b1;
        n_checks++;
        if (!done || pops.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_pops: got %0d pops (done=%0d) want 2", pops.size(), done);
        end
        if (pops.size() == 2) begin
            n_checks++;
            if (pops[1] - pops[0] !== 5) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d cycles want 5", pops[1] - pops[0]);
            end
        end
        n_checks++;
        if (consec !== 0) begin
            n_fail++;
            $display("FAIL b2b_consec: got %0d back-to-back q_read cycles want 0", consec);
        end
        n_checks++;
        if (px.size() !== 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pixels want 6", px.size());
        end
        for (int i = 0; i < px.size() && i < 6; i++) begin
            n_checks++;
            if (px[i] !== exp_x[i] || py[i] !== exp_y[i] || pc[i] !== exp_c[i]) begin
                n_fail++;
                $display("FAIL b2b_pix[%0d]: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                         i, px[i], py[i], pc[i], exp_x[i], exp_y[i], exp_c[i]);
            end
        end
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++;
            if (q_read !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_idle_pop: q_read=%b with queue empty want 0", q_read);
            end
        end
    endtask

    task automatic test_reset_mid_line();
        int  accepted = 0;
        bit  popped = 1'b0;
        for (int c = 0; c < 50 && accepted < 4; c++) begin
            @(negedge clk);
            if (!popped) begin
                drive_head(0, 0, 800, 0, 1); q_empty = 1'b0;
            end else begin
                q_empty = 1'b1;
            end
            pix_ready = 1'b1;
            #1;
            if (q_read) popped = 1'b1;
            if (pix_valid) accepted++;
        end
        n_checks++;
        if (accepted !== 4) begin
            n_fail++;
            $display("FAIL rstmid_setup: got %0d pixels before reset want 4", accepted);
        end
        @(negedge clk);
        rst = 1'b1; q_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (pix_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_valid: pix_valid=%b busy=%b after reset want 0 0", pix_valid, busy);
        end
        repeat (3) begin
            @(negedge clk); #1;
            n_checks++;
            if (q_read !== 1'b0 || pix_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_quiet: q_read=%b pix_valid=%b want 0 0", q_read, pix_valid);
            end
        end
        run_line(0, 0, 0, 0, 2, 0);
        n_checks++;
        if (qread_cnt !== 1 || acc_x.size() !== 1) begin
            n_fail++;
            $display("FAIL rstmid_recover: pops=%0d pixels=%0d want 1 1", qread_cnt, acc_x.size());
        end else begin
            n_checks++;
            if (acc_x[0] !== 320 || acc_y[0] !== 240) begin
                n_fail++;
                $display("FAIL rstmid_pix: got (%0d,%0d) want (320,240)", acc_x[0], acc_y[0]);
            end
        end
    endtask

    task automatic test_point_blank();
        run_line(8, 8, 8, 8, 7, 0);
        n_checks++;
        if (acc_x.size() !== 1) begin
            n_fail++;
            $display("FAIL point_count: got %0d pixels want 1", acc_x.size());
        end else begin
            n_checks++;
            if (acc_x[0] !== 321 || acc_y[0] !== 239 || acc_c[0] !== 7) begin
                n_fail++;
                $display("FAIL point_pix: got (%0d,%0d,c%0d) want (321,239,c7)", acc_x[0], acc_y[0], acc_c[0]);
            end
        end
        n_checks++;
        if (busy_cnt !== 2) begin
            n_fail++;
            $display("FAIL point_busy: got %0d busy cycles want 2", busy_cnt);
        end
        run_line(8, 8, 8, 8, 0, 0);
`ifdef LINE_RASTER_BLANK_DROP_EN
        n_checks++;
        if (acc_x.size() !== 0 || first_v !== -1) begin
            n_fail++;
            $display("FAIL blank_drop: got %0d pixels (first valid %0d) want none", acc_x.size(), first_v);
        end
        n_checks++;
        if (busy_cnt !== 1) begin
            n_fail++;
            $display("FAIL blank_busy: got %0d busy cycles want 1", busy_cnt);
        end
`else
        n_checks++;
        if (acc_x.size() !== 1) begin
            n_fail++;
            $display("FAIL blank_count: got %0d pixels want 1", acc_x.size());
        end else begin
            n_checks++;
            if (acc_x[0] !== 321 || acc_y[0] !== 239 || acc_c[0] !== 0) begin
                n_fail++;
                $display("FAIL blank_pix: got (%0d,%0d,c%0d) want (321,239,c0)", acc_x[0], acc_y[0], acc_c[0]);
            end
        end
`endif
    endtask

    initial begin
        rst = 1'b1; q_empty = 1'b1; pix_ready = 1'b1;
        drive_head(0, 0, 0, 0, 0);
        test_reset();
        test_horizontal();
        test_diagonal();
        test_clip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_line();
        test_point_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
